mem_loader: RTL and testbench

- Boot loader directly upstream of the unified instruction/data memory.
- Accepts a little-endian byte stream (valid/ready), parses a two-word header, assembles 32-bit words and writes them into the instruction region (word addr 0x000..0x0FF) and the data region (0x100..0x1FF).
- While loading, owns the memory port and holds the CPU stalled. When idle or done, passes CPU memory requests through unchanged.

---
 rtl/mem_loader_pkg.sv | 23 ++
 rtl/mem_loader_byte_word_packer.sv | 38 +++
 rtl/mem_loader.sv | 157 +++++++++++++++
 tb/tb_mem_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared definitions for the boot loader slice.
//   state_t        loader FSM states
//   INST_BASE      word address of the instruction region
//   LDR_DATA_BASE  default word address of the data region
//   WORD_W/BYTE_W  memory word and stream byte widths
package mem_loader_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BYTE_W        = 8;
    localparam logic [31:0] INST_BASE     = 32'h0000_0000;
    localparam logic [31:0] LDR_DATA_BASE = 32'h0000_0100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_I,
        ST_HDR_D,
        ST_LOAD_I,
        ST_LOAD_D,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/mem_loader_byte_word_packer.sv
// byte_word_packer: assembles little-endian bytes into 32-bit words.
//   i_clk, i_rst  clock / synchronous active-high reset
//   clr           synchronous clear of byte counter and partial word
//   byte_en       a byte is accepted this cycle
//   byte_in       the accepted byte
//   word_valid    this accepted byte completes a word (combinational)
//   word          completed word, valid while word_valid is high
module byte_word_packer
    import mem_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]               byte_cnt;
    // Holds the three most recent bytes; the incoming byte is always the MSB,
    // so after four bytes byte 0 has shifted down to bits [7:0].
    logic [WORD_W-BYTE_W-1:0] shreg;

    assign word_valid = byte_en && (byte_cnt == 2'd3);
    assign word       = {byte_in, shreg};

    always_ff @(posedge i_clk) begin
        if (i_rst || clr) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= word[WORD_W-1:BYTE_W];
        end
    end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: boot loader in front of the unified instruction/data memory.
// Parses a two-word header (instruction count, data count) from a byte stream,
// then writes the payload words to the instruction and data regions. While
// loading it owns the memory port (o_busy); otherwise CPU requests pass through.
//   i_clk, i_rst                     clock / synchronous active-high reset
//   i_start                          begin a load (IDLE/DONE/ERR only)
//   i_byte_valid, i_byte, o_byte_ready  byte stream handshake
//   i_cpu_addr, i_cpu_we, i_cpu_wdata  CPU memory request
//   o_mem_addr, o_mem_we, o_mem_wdata  memory port
//   o_busy, o_done, o_err            status
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_INST = 256,
    parameter int unsigned DEPTH_DATA = 256,
    parameter logic [31:0] DATA_BASE  = LDR_DATA_BASE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    input  logic [31:0] i_cpu_addr,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    state_t      state, state_n;
    logic [31:0] n_i, n_i_n;
    logic [31:0] n_d, n_d_n;
    logic [31:0] idx, idx_n;
    logic        wr_pend, wr_pend_n;
    logic [31:0] wr_addr, wr_addr_n;
    logic [31:0] wr_data, wr_data_n;
    logic        pk_clr;
    logic        accept;
    logic        word_valid;
    logic [31:0] word;

    assign o_byte_ready = (state == ST_HDR_I) || (state == ST_HDR_D) ||
                          (state == ST_LOAD_I) || (state == ST_LOAD_D);
    assign accept       = i_byte_valid && o_byte_ready;

    byte_word_packer u_packer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .clr        (pk_clr),
        .byte_en    (accept),
        .byte_in    (i_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            n_i     <= '0;
            n_d     <= '0;
            idx     <= '0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            n_i     <= n_i_n;
            n_d     <= n_d_n;
            idx     <= idx_n;
            wr_pend <= wr_pend_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        n_i_n     = n_i;
        n_d_n     = n_d;
        idx_n     = idx;
        wr_pend_n = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        pk_clr    = 1'b0;

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // A final write may still be pending in DONE; the loader is
                // busy then, so a start request is ignored.
                if (i_start && !wr_pend) begin
                    state_n = ST_HDR_I;
                    pk_clr  = 1'b1;
                    n_i_n   = '0;
                    n_d_n   = '0;
                    idx_n   = '0;
                end
            end
            ST_HDR_I: begin
                if (word_valid) begin
                    n_i_n   = word;
                    state_n = (word > DEPTH_INST) ? ST_ERR : ST_HDR_D;
                end
            end
            ST_HDR_D: begin
                if (word_valid) begin
                    n_d_n = word;
                    if (word > DEPTH_DATA)   state_n = ST_ERR;
                    else if (n_i != '0)      state_n = ST_LOAD_I;
                    else if (word != '0)     state_n = ST_LOAD_D;
                    else                     state_n = ST_DONE;
                end
            end
            ST_LOAD_I: begin
                if (word_valid) begin
                    wr_pend_n = 1'b1;
                    wr_addr_n = INST_BASE + idx;
                    wr_data_n = word;
                    if (idx == n_i - 32'd1) begin
                        idx_n   = '0;
                        state_n = (n_d != '0) ? ST_LOAD_D : ST_DONE;
                    end else begin
                        idx_n = idx + 32'd1;
                    end
                end
            end
            ST_LOAD_D: begin
                if (word_valid) begin
                    wr_pend_n = 1'b1;
                    wr_addr_n = DATA_BASE + idx;
                    wr_data_n = word;
                    if (idx == n_d - 32'd1) begin
                        idx_n   = '0;
                        state_n = ST_DONE;
                    end else begin
                        idx_n = idx + 32'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign o_busy = o_byte_ready || wr_pend;
    // o_done waits for the final write pulse to retire.
    assign o_done = (state == ST_DONE) && !wr_pend;
    assign o_err  = (state == ST_ERR);

    assign o_mem_addr  = o_busy ? wr_addr : i_cpu_addr;
    assign o_mem_we    = o_busy ? wr_pend : i_cpu_we;
    assign o_mem_wdata = o_busy ? wr_data : i_cpu_wdata;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed self-checking bench for mem_loader with a simple
// instruction/data memory model on the memory port.
module tb_mem_loader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = '0;
    logic        o_byte_ready;
    logic [31:0] i_cpu_addr = '0;
    logic        i_cpu_we = 1'b0;
    logic [31:0] i_cpu_wdata = '0;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [31:0] o_mem_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    mem_loader #(
        .DEPTH_INST (256),
        .DEPTH_DATA (256),
        .DATA_BASE  (32'h100)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .i_cpu_addr   (i_cpu_addr),
        .i_cpu_we     (i_cpu_we),
        .i_cpu_wdata  (i_cpu_wdata),
        .o_mem_addr   (o_mem_addr),
        .o_mem_we     (o_mem_we),
        .o_mem_wdata  (o_mem_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Memory model: bit 8 of the word address selects the data region.
    logic [31:0] inst_mem [256];
    logic [31:0] data_mem [256];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    always @(posedge i_clk) begin
        if (o_mem_we) begin
            if (o_mem_addr[8]) data_mem[o_mem_addr[7:0]] <= o_mem_wdata;
            else               inst_mem[o_mem_addr[7:0]] <= o_mem_wdata;
            log_addr.push_back(o_mem_addr);
            log_data.push_back(o_mem_wdata);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned waited;
        repeat (gap) tick();
        i_byte_valid = 1'b1;
        i_byte       = b;
        waited       = 0;
        while (!o_byte_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("byte_ready_timeout", 32'd0, 32'd1);
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned max_gap);
        logic [31:0] v;
        v = w;
        for (int unsigned k = 0; k < 4; k++) begin
            send_byte(v[7:0], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
            v = v >> 8;
        end
    endtask

    function automatic logic [31:0] t4_word(input int unsigned i);
        return 32'h1000_0000 + i * 32'h0001_0003;
    endfunction

    initial begin
        logic [31:0] snap;
        int unsigned base;
        logic [31:0] p [3];
        logic [31:0] a [3];
        p[0] = 32'h2008_0005; p[1] = 32'h2109_0001; p[2] = 32'hDEAD_BEEF;
        a[0] = 32'h000;       a[1] = 32'h001;       a[2] = 32'h100;

        // Reset state
        repeat (3) tick();
        check("rst_busy",  {31'd0, o_busy}, 32'd0);
        check("rst_done",  {31'd0, o_done}, 32'd0);
        check("rst_err",   {31'd0, o_err}, 32'd0);
        check("rst_ready", {31'd0, o_byte_ready}, 32'd0);
        check("rst_we",    {31'd0, o_mem_we}, 32'd0);
        i_rst = 1'b0;
        tick();

        // Byte valid while idle is ignored
        i_byte_valid = 1'b1; i_byte = 8'h55;
        tick();
        i_byte_valid = 1'b0;
        check("idle_ignore_ready", {31'd0, o_byte_ready}, 32'd0);

        // T1: N_I=2, N_D=1, with a blocked CPU write to 0x105 during the load
        pulse_start();
        check("t1_ready", {31'd0, o_byte_ready}, 32'd1);
        check("t1_busy",  {31'd0, o_busy}, 32'd1);
        send_word(32'd2, 0);
        send_word(32'd1, 0);
        check("t1_hdr_no_write", log_addr.size(), 32'd0);
        snap        = data_mem[5];
        i_cpu_addr  = 32'h105;
        i_cpu_wdata = 32'h5555_5555;
        i_cpu_we    = 1'b1;
        for (int unsigned w = 0; w < 3; w++) begin
            send_word(p[w], 0);
            check($sformatf("t1_we_%0d", w),    {31'd0, o_mem_we}, 32'd1);
            check($sformatf("t1_addr_%0d", w),  o_mem_addr, a[w]);
            check($sformatf("t1_wdata_%0d", w), o_mem_wdata, p[w]);
        end
        i_cpu_we = 1'b0;
        check("t1_busy_last_write", {31'd0, o_busy}, 32'd1);
        check("t1_done_early",      {31'd0, o_done}, 32'd0);
        tick();
        check("t1_done",  {31'd0, o_done}, 32'd1);
        check("t1_busy0", {31'd0, o_busy}, 32'd0);
        check("t1_nwr",   log_addr.size(), 32'd3);
        check("t1_mem_i0", inst_mem[0], 32'h2008_0005);
        check("t1_mem_i1", inst_mem[1], 32'h2109_0001);
        check("t1_mem_d0", data_mem[0], 32'hDEAD_BEEF);
        check("t1_cpu_we_dropped", data_mem[5], snap);

        // CPU write after done goes through
        i_cpu_addr = 32'h105; i_cpu_wdata = 32'hCAFE_F00D; i_cpu_we = 1'b1;
        tick();
        i_cpu_we = 1'b0;
        check("t1_cpu_write", data_mem[5], 32'hCAFE_F00D);

        // T2: empty image
        base = log_addr.size();
        pulse_start();
        send_word(32'd0, 0);
        send_word(32'd0, 0);
        check("t2_done",   {31'd0, o_done}, 32'd1);
        check("t2_busy",   {31'd0, o_busy}, 32'd0);
        check("t2_nowr",   log_addr.size(), base);
        i_cpu_addr = 32'h100;
        #1;
        check("t2_pass_addr", o_mem_addr, 32'h100);
        check("t2_pass_we",   {31'd0, o_mem_we}, 32'd0);
        i_byte_valid = 1'b1; i_byte = 8'hAA;
        tick();
        i_byte_valid = 1'b0;
        check("t2_ignore_done",  {31'd0, o_done}, 32'd1);
        check("t2_ignore_ready", {31'd0, o_byte_ready}, 32'd0);

        // T3: N_I=257 is an error
        pulse_start();
        send_word(32'd257, 0);
        check("t3_err",   {31'd0, o_err}, 32'd1);
        check("t3_ready", {31'd0, o_byte_ready}, 32'd0);
        check("t3_busy",  {31'd0, o_busy}, 32'd0);
        check("t3_done",  {31'd0, o_done}, 32'd0);
        check("t3_nowr",  log_addr.size(), base);

        // T4: N_I=256 (boundary, legal) with random valid gaps
        pulse_start();
        check("t4_err_cleared", {31'd0, o_err}, 32'd0);
        send_word(32'd256, 0);
        send_word(32'd0, 0);
        for (int unsigned i = 0; i < 256; i++) send_word(t4_word(i), 2);
        tick();
        check("t4_done", {31'd0, o_done}, 32'd1);
        check("t4_nwr",  log_addr.size(), base + 256);
        for (int unsigned i = 0; i < 256; i++) begin
            if (base + i < log_addr.size()) begin
                check($sformatf("t4_addr_%0d", i), log_addr[base + i], i);
                check($sformatf("t4_data_%0d", i), log_data[base + i], t4_word(i));
            end
        end
        check("t4_last", inst_mem[255], t4_word(255));

        // T5: reset mid-load, then reload; a start during the header is ignored
        pulse_start();
        send_word(32'd2, 0);
        send_word(32'd0, 0);
        send_word(32'h0102_0304, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        i_rst = 1'b1;
        tick();
        check("t5_rst_busy",  {31'd0, o_busy}, 32'd0);
        check("t5_rst_ready", {31'd0, o_byte_ready}, 32'd0);
        check("t5_rst_done",  {31'd0, o_done}, 32'd0);
        check("t5_rst_err",   {31'd0, o_err}, 32'd0);
        check("t5_rst_we",    {31'd0, o_mem_we}, 32'd0);
        i_rst = 1'b0;
        tick();
        base = log_addr.size();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_word(32'd1, 0);
        send_word(32'h89AB_CDEF, 0);
        send_word(32'h7654_3210, 0);
        tick();
        check("t5_done",  {31'd0, o_done}, 32'd1);
        check("t5_nwr",   log_addr.size(), base + 2);
        check("t5_mem_i", inst_mem[0], 32'h89AB_CDEF);
        check("t5_mem_d", data_mem[0], 32'h7654_3210);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "timeout");
    end

endmodule
